// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, register-number width and the stage-control bundle.
package pipe_ctrl_pkg;

    localparam int REG_W                = 5;
    localparam int MEM_WAIT_MAX_DEFAULT = 8;

    typedef logic [REG_W-1:0] reg_num_t;

    // Encoding 2'd3 is deliberately unnamed; the controller treats it as RUN.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_FLUSH = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write_en;
        logic if_id_write_en;
        logic id_ex_write_en;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{pc_write_en: 1'b1, if_id_write_en: 1'b1,
                                   id_ex_write_en: 1'b1, if_id_flush: 1'b0,
                                   id_ex_bubble: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pc_write_en: 1'b0, if_id_write_en: 1'b0,
                                      id_ex_write_en: 1'b0, if_id_flush: 1'b0,
                                      id_ex_bubble: 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{pc_write_en: 1'b0, if_id_write_en: 1'b0,
                                        id_ex_write_en: 1'b1, if_id_flush: 1'b0,
                                        id_ex_bubble: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{pc_write_en: 1'b1, if_id_write_en: 1'b1,
                                      id_ex_write_en: 1'b1, if_id_flush: 1'b1,
                                      id_ex_bubble: 1'b1};
    localparam ctrl_t CTRL_FLUSH_ONLY = '{pc_write_en: 1'b1, if_id_write_en: 1'b1,
                                          id_ex_write_en: 1'b1, if_id_flush: 1'b1,
                                          id_ex_bubble: 1'b0};
    localparam ctrl_t CTRL_RESET = '{pc_write_en: 1'b0, if_id_write_en: 1'b0,
                                     id_ex_write_en: 1'b0, if_id_flush: 1'b1,
                                     id_ex_bubble: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the controller (slave).
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_num_t id_rs;
    reg_num_t id_rt;
    logic     id_ex_mem_read;
    reg_num_t id_ex_rd;
    logic     ex_branch_taken;
    logic     mem_busy;

    logic     pc_write_en;
    logic     if_id_write_en;
    logic     id_ex_write_en;
    logic     if_id_flush;
    logic     id_ex_bubble;

    modport master (
        output id_rs, id_rt, id_ex_mem_read, id_ex_rd, ex_branch_taken, mem_busy,
        input  pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_bubble
    );

    modport slave (
        input  id_rs, id_rt, id_ex_mem_read, id_ex_rd, ex_branch_taken, mem_busy,
        output pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_bubble
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX writing a register the ID instruction reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  reg_num_t id_rs,
    input  reg_num_t id_rt,
    input  logic     id_ex_mem_read,
    input  reg_num_t id_ex_rd,
    output logic     load_use
);

    // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      ((id_ex_rd == id_rs) || (id_ex_rd == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and memory-busy freezes,
// plus a saturating stall counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W  = 16,
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
    typedef logic [WAIT_W-1:0] wait_cnt_t;
    localparam wait_cnt_t WAIT_LIMIT = wait_cnt_t'(MEM_WAIT_MAX);

    state_e                 state_q, state_d;
    wait_cnt_t              wait_cnt_q, wait_cnt_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    ctrl_t     ctrl;
    ctrl_t     ctrl_out;
    wait_cnt_t busy_run;
    logic      load_use;

    load_use_detect u_load_use_detect (
        .id_rs          (hz.id_rs),
        .id_rt          (hz.id_rt),
        .id_ex_mem_read (hz.id_ex_mem_read),
        .id_ex_rd       (hz.id_ex_rd),
        .load_use       (load_use)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ctrl          = CTRL_RUN;
        state_d       = ST_RUN;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        busy_run      = '0;

        if (hz.mem_busy) begin
            // A busy memory outranks everything and freezes the whole pipeline.
            ctrl     = CTRL_FREEZE;
            busy_run = (state_q == ST_MEM_WAIT) ? wait_cnt_q + 1'b1 : wait_cnt_t'(1);
            if (busy_run == WAIT_LIMIT) begin
                mem_timeout_d = 1'b1;
                state_d       = ST_RUN;
            end else begin
                wait_cnt_d = busy_run;
                state_d    = ST_MEM_WAIT;
            end
        end else begin
            case (state_q)
                ST_BR_FLUSH: begin
                    // Second flush cycle covers the fetch already in flight.
                    ctrl    = CTRL_FLUSH_ONLY;
                    state_d = ST_RUN;
                end
                default: begin
                    // RUN, the exit cycle of MEM_WAIT and the unused encoding all decide as RUN.
                    if (hz.ex_branch_taken) begin
                        ctrl    = CTRL_BRANCH;
                        state_d = ST_BR_FLUSH;
                    end else if (load_use) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
            endcase
        end

        stall_count_d = stall_count_q;
        if (!ctrl.pc_write_en && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    // While reset is held the pipeline is kept flushed and bubbled with no stage advancing.
    assign ctrl_out = reset ? CTRL_RESET : ctrl;

    assign hz.pc_write_en    = ctrl_out.pc_write_en;
    assign hz.if_id_write_en = ctrl_out.if_id_write_en;
    assign hz.id_ex_write_en = ctrl_out.id_ex_write_en;
    assign hz.if_id_flush    = ctrl_out.if_id_flush;
    assign hz.id_ex_bubble   = ctrl_out.id_ex_bubble;

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: two controller instances (default and small parameters) share stimulus
// and are compared every cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic     reset;
    reg_num_t rs, rt, rd;
    logic     mr, br, busy;

    pipeline_hazard_ctrl_if if0 ();
    pipeline_hazard_ctrl_if if1 ();

    assign if0.id_rs = rs;  assign if0.id_rt = rt;  assign if0.id_ex_rd = rd;
    assign if0.id_ex_mem_read = mr;  assign if0.ex_branch_taken = br;  assign if0.mem_busy = busy;
    assign if1.id_rs = rs;  assign if1.id_rt = rt;  assign if1.id_ex_rd = rd;
    assign if1.id_ex_mem_read = mr;  assign if1.ex_branch_taken = br;  assign if1.mem_busy = busy;

    logic [1:0]  st0, st1;
    logic [15:0] sc0;
    logic [1:0]  sc1;
    logic        to0, to1;

    pipeline_hazard_ctrl #(.STALL_CNT_W(16), .MEM_WAIT_MAX(8)) dut (
        .clk(clk), .reset(reset), .hz(if0), .state(st0), .stall_count(sc0), .mem_timeout(to0)
    );

    pipeline_hazard_ctrl #(.STALL_CNT_W(2), .MEM_WAIT_MAX(3)) dut_small (
        .clk(clk), .reset(reset), .hz(if1), .state(st1), .stall_count(sc1), .mem_timeout(to1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: per instance, the run of consecutive busy cycles, whether a branch flush
    // still owes its second cycle, the sticky timeout and the saturating stall tally.
    int   lim[2] = '{8, 3};
    int   sat[2] = '{65535, 3};
    int   streak[2];
    bit   owe_flush[2];
    bit   tmo[2];
    int   stalls[2];

    function automatic logic [4:0] dut_ctrl(int i);
        if (i == 0) return {if0.pc_write_en, if0.if_id_write_en, if0.id_ex_write_en,
                            if0.if_id_flush, if0.id_ex_bubble};
        return {if1.pc_write_en, if1.if_id_write_en, if1.id_ex_write_en,
                if1.if_id_flush, if1.id_ex_bubble};
    endfunction

    function automatic logic [31:0] dut_state(int i);  return (i == 0) ? 32'(st0) : 32'(st1);  endfunction
    function automatic logic [31:0] dut_stall(int i);  return (i == 0) ? 32'(sc0) : 32'(sc1);  endfunction
    function automatic logic [31:0] dut_tmo(int i);    return (i == 0) ? 32'(to0) : 32'(to1);  endfunction

    function automatic logic [4:0] model_ctrl(int i);
        bit hazard = mr && (rd != 0) && (rd == rs || rd == rt);
        if (busy)         return 5'b00000;
        if (owe_flush[i]) return 5'b11110;
        if (br)           return 5'b11111;
        if (hazard)       return 5'b00101;
        return 5'b11100;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            streak[i] = 0; owe_flush[i] = 0; tmo[i] = 0; stalls[i] = 0;
        end
    endtask

    // Called #1 after inputs change at the falling edge; the next rising edge follows.
    task automatic step_and_check();
        for (int i = 0; i < 2; i++) begin
            logic [4:0] exp_ctrl = model_ctrl(i);
            int exp_state = (streak[i] > 0) ? 2 : (owe_flush[i] ? 1 : 0);
            check($sformatf("ctrl%0d", i), 32'(dut_ctrl(i)), 32'(exp_ctrl));
            check($sformatf("state%0d", i), dut_state(i), exp_state);
            check($sformatf("stall%0d", i), dut_stall(i), stalls[i]);
            check($sformatf("timeout%0d", i), dut_tmo(i), 32'(tmo[i]));
            if (!exp_ctrl[4]) stalls[i] = (stalls[i] + 1 > sat[i]) ? sat[i] : stalls[i] + 1;
            if (busy) begin
                streak[i]++;
                owe_flush[i] = 0;
                if (streak[i] >= lim[i]) begin
                    tmo[i] = 1;
                    streak[i] = 0;
                end
            end else begin
                streak[i] = 0;
                owe_flush[i] = !owe_flush[i] && br;
            end
        end
    endtask

    task automatic cycle(input int a_rs, input int a_rt, input int a_rd,
                         input bit a_mr, input bit a_br, input bit a_busy);
        @(negedge clk);
        rs = reg_num_t'(a_rs); rt = reg_num_t'(a_rt); rd = reg_num_t'(a_rd);
        mr = a_mr; br = a_br; busy = a_busy;
        #1;
        step_and_check();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ctrl%0d", tag, i), 32'(dut_ctrl(i)), 32'h03);
            check($sformatf("%s_state%0d", tag, i), dut_state(i), 0);
            check($sformatf("%s_stall%0d", tag, i), dut_stall(i), 0);
            check($sformatf("%s_tmo%0d", tag, i), dut_tmo(i), 0);
        end
    endtask

    // Asserts reset between clock edges so the asynchronous clear is observed without an edge.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        rs = '0; rt = '0; rd = '0; mr = 1'b0; br = 1'b0; busy = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int burst = 0;
        reset = 1'b1;
        rs = '0; rt = '0; rd = '0; mr = 1'b0; br = 1'b0; busy = 1'b0;
        model_reset();
        #2;
        check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Single load-use stall, then a load to r0 that must not stall.
        cycle(5, 0, 5, 1'b1, 1'b0, 1'b0);
        idle();
        check("loaduse_stall_count", 32'(sc0), 1);
        cycle(0, 0, 0, 1'b1, 1'b0, 1'b0);
        idle();
        check("r0_no_stall", 32'(sc0), 1);

        // Branch with a simultaneous load-use match: branch wins, then one flush-only cycle.
        apply_reset("rst_a");
        cycle(7, 3, 7, 1'b1, 1'b1, 1'b0);
        cycle(7, 3, 7, 1'b1, 1'b1, 1'b0);
        idle();
        check("branch_state", 32'(st0), 0);
        check("branch_stalls", 32'(sc0), 0);

        // Three busy cycles.
        apply_reset("rst_b");
        repeat (3) cycle(1, 2, 3, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        check("busy3_stalls", 32'(sc0), 3);
        check("busy3_tmo", 32'(to0), 0);
        check("busy3_state", 32'(st0), 0);

        // Ten busy cycles overrun both timeout limits.
        apply_reset("rst_c");
        repeat (10) cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle();
        idle();
        check("busy10_tmo0", 32'(to0), 1);
        check("busy10_tmo1", 32'(to1), 1);
        check("busy10_state", 32'(st0), 0);

        // Five load stalls saturate the 2-bit counter.
        apply_reset("rst_d");
        repeat (5) begin
            cycle(9, 4, 9, 1'b1, 1'b0, 1'b0);
            idle();
        end
        check("sat_small", 32'(sc1), 3);
        check("sat_wide", 32'(sc0), 5);

        // Reset landing in the middle of MEM_WAIT and of BR_FLUSH.
        cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle(0, 0, 0, 1'b0, 1'b0, 1'b1);
        apply_reset("rst_memwait");
        cycle(0, 0, 0, 1'b0, 1'b1, 1'b0);
        apply_reset("rst_brflush");

        // Randomised traffic with occasional long busy bursts.
        repeat (3000) begin
            bit b;
            if (burst > 0) begin
                b = 1'b1;
                burst--;
            end else if ($urandom_range(0, 15) == 0) begin
                burst = int'($urandom_range(1, 11));
                b = 1'b1;
            end else begin
                b = 1'b0;
            end
            cycle(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
